// File: rtl/prom_7116_reader.sv
// Burst reader for a 512x4 asynchronous PROM (7116-class): presents ADDR..ADDR+COUNT
// one nibble at a time on a VALID/READY stream, covering access and disable times with counters.
module prom_7116_reader #(
  parameter int WAIT_CYCLES = 3,
  parameter int DIS_CYCLES  = 2
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       START,
  input  logic [8:0] ADDR,
  input  logic [8:0] COUNT,
  output logic       BUSY,
  output logic [3:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       DONE,
  output logic       nE,
  output logic [8:0] A,
  input  logic [3:0] Q
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRESENT,
    ST_GAP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [3:0] GAP_INIT  = 4'(DIS_CYCLES);

  state_t     state_q, state_d;
  logic [8:0] a_q, a_d;
  logic       ne_q, ne_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [8:0] rem_q, rem_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ne_d    = ne_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    wait_d  = wait_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = ADDR;
          ne_d    = 1'b0;
          busy_d  = 1'b1;
          rem_d   = COUNT;
          wait_d  = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end

      // Capture happens one edge after the counter has run down, giving WAIT_CYCLES+1 edges of access time
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          data_d  = Q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_PRESENT: begin
        if (READY) begin
          valid_d = 1'b0;
          if (rem_q != 9'd0) begin
            a_d     = a_q + 9'd1;
            rem_d   = rem_q - 9'd1;
            wait_d  = WAIT_INIT;
            state_d = ST_WAIT;
          end else begin
            done_d  = 1'b1;
            ne_d    = 1'b1;
            gap_d   = GAP_INIT;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      a_q     <= 9'd0;
      ne_q    <= 1'b1;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= 9'd0;
      wait_q  <= 4'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ne_q    <= ne_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
    end
  end

  assign BUSY  = busy_q;
  assign DATA  = data_q;
  assign VALID = valid_q;
  assign DONE  = done_q;
  assign nE    = ne_q;
  assign A     = a_q;

endmodule

// File: tb/tb_prom_7116_reader.sv
// Directed bench for prom_7116_reader with a behavioural PROM (tAA = 45 ns, Q = X while disabled).
module tb_prom_7116_reader;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       START = 1'b0;
  logic [8:0] ADDR = 9'd0;
  logic [8:0] COUNT = 9'd0;
  logic       BUSY;
  logic [3:0] DATA;
  logic       VALID;
  logic       READY = 1'b0;
  logic       DONE;
  logic       nE;
  logic [8:0] A;
  logic [3:0] Q;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int done_seen = 0;

  prom_7116_reader #(
    .WAIT_CYCLES(3),
    .DIS_CYCLES (2)
  ) dut (
    .CLK   (CLK),
    .nRESET(nRESET),
    .START (START),
    .ADDR  (ADDR),
    .COUNT (COUNT),
    .BUSY  (BUSY),
    .DATA  (DATA),
    .VALID (VALID),
    .READY (READY),
    .DONE  (DONE),
    .nE    (nE),
    .A     (A),
    .Q     (Q)
  );

  always #10 CLK = ~CLK;

  function automatic logic [3:0] prom_val(input logic [8:0] a);
    return a[3:0] ^ a[7:4] ^ {a[8], a[8], a[8], a[8]} ^ 4'h5;
  endfunction

  // Output goes unknown on any address/enable change and settles tAA later
  always @(A or nE) begin
    Q <= 4'bxxxx;
    if (nE === 1'b0) Q <= #45 prom_val(A);
  end

  always @(negedge CLK) if (DONE === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (VALID !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("valid_timeout", 16'(VALID), 16'd1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check("idle_timeout", 16'(BUSY), 16'd0);
  endtask

  initial begin
    int n;
    int base;
    int xfers;
    int cyc;
    int ne_bad;
    logic [8:0] exp_a;
    logic [3:0] held_data;

    // Reset values
    #25;
    check("rst_ne", 16'(nE), 16'd1);
    check("rst_a", 16'(A), 16'd0);
    check("rst_data", 16'(DATA), 16'd0);
    check("rst_valid", 16'(VALID), 16'd0);
    check("rst_busy", 16'(BUSY), 16'd0);
    check("rst_done", 16'(DONE), 16'd0);
    #10 nRESET = 1'b1;

    // Single read, first START after reset
    ADDR = 9'h0A5; COUNT = 9'd0; READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    check("s1_busy", 16'(BUSY), 16'd1);
    check("s1_ne", 16'(nE), 16'd0);
    check("s1_a", 16'(A), 16'h0A5);
    check("s1_valid0", 16'(VALID), 16'd0);
    repeat (3) tick();
    check("s1_valid_early", 16'(VALID), 16'd0);
    tick();
    check("s1_valid", 16'(VALID), 16'd1);
    check("s1_data", 16'(DATA), 16'(prom_val(9'h0A5)));
    tick();
    check("s1_done", 16'(DONE), 16'd1);
    check("s1_valid_fall", 16'(VALID), 16'd0);
    check("s1_ne_off", 16'(nE), 16'd1);
    check("s1_data_hold", 16'(DATA), 16'(prom_val(9'h0A5)));
    tick();
    check("s1_done_pulse", 16'(DONE), 16'd0);
    check("s1_busy_gap", 16'(BUSY), 16'd1);
    tick();
    check("s1_busy_gap2", 16'(BUSY), 16'd1);
    tick();
    check("s1_busy_end", 16'(BUSY), 16'd0);

    // Wrap burst 0x1FE..0x001 at full rate
    base = done_seen;
    ADDR = 9'h1FE; COUNT = 9'd3; READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_a = 9'h1FE + 9'(k);
      wait_valid(12, n);
      check("wrap_lat", 16'(n), 16'd4);
      check("wrap_a", 16'(A), 16'(exp_a));
      check("wrap_data", 16'(DATA), 16'(prom_val(exp_a)));
      check("wrap_ne", 16'(nE), 16'd0);
      tick();
      check("wrap_done", 16'(DONE), 16'(k == 3));
    end
    wait_idle(10);
    check("wrap_done_count", 16'(done_seen - base), 16'd1);

    // Backpressure: READY low for 5 cycles while VALID
    ADDR = 9'h010; COUNT = 9'd1; READY = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    wait_valid(12, n);
    check("bp_lat", 16'(n), 16'd4);
    held_data = DATA;
    check("bp_data", 16'(held_data), 16'(prom_val(9'h010)));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 16'(VALID), 16'd1);
      check("bp_data_hold", 16'(DATA), 16'(held_data));
      check("bp_a_hold", 16'(A), 16'h010);
      check("bp_ne_hold", 16'(nE), 16'd0);
    end
    READY = 1'b1;
    tick();
    check("bp_valid_fall", 16'(VALID), 16'd0);
    check("bp_a_next", 16'(A), 16'h011);
    check("bp_no_done", 16'(DONE), 16'd0);
    wait_valid(12, n);
    check("bp_data2", 16'(DATA), 16'(prom_val(9'h011)));
    tick();
    check("bp_done", 16'(DONE), 16'd1);
    wait_idle(10);

    // START held high: only accepted once BUSY has dropped
    ADDR = 9'h020; COUNT = 9'd0; READY = 1'b1; START = 1'b1;
    tick();
    check("br_a", 16'(A), 16'h020);
    ADDR = 9'h0FF; COUNT = 9'd5;
    tick();
    check("br_a_ignored", 16'(A), 16'h020);
    n = 0;
    while (DONE !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("br_done_seen", 16'(DONE), 16'd1);
    COUNT = 9'd0;
    n = 0;
    while (BUSY !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("br_gap_len", 16'(n), 16'd3);
    check("br_idle_a", 16'(A), 16'h020);
    tick();
    check("br_restart_busy", 16'(BUSY), 16'd1);
    check("br_restart_a", 16'(A), 16'h0FF);
    START = 1'b0;
    wait_idle(40);

    // Asynchronous reset during WAIT of nibble 2
    ADDR = 9'h100; COUNT = 9'd3; READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    wait_valid(12, n);
    tick();
    check("rm_a", 16'(A), 16'h101);
    tick();
    #5 nRESET = 1'b0;
    #1;
    check("rm_ne", 16'(nE), 16'd1);
    check("rm_valid", 16'(VALID), 16'd0);
    check("rm_busy", 16'(BUSY), 16'd0);
    check("rm_a0", 16'(A), 16'd0);
    check("rm_data0", 16'(DATA), 16'd0);
    tick();
    #5 nRESET = 1'b1;
    ADDR = 9'h033; COUNT = 9'd0; START = 1'b1;
    tick();
    START = 1'b0;
    check("rr_busy", 16'(BUSY), 16'd1);
    check("rr_a", 16'(A), 16'h033);
    wait_valid(12, n);
    check("rr_lat", 16'(n), 16'd4);
    check("rr_data", 16'(DATA), 16'(prom_val(9'h033)));
    tick();
    check("rr_done", 16'(DONE), 16'd1);
    wait_idle(10);

    // Full 512-nibble sweep with random READY
    base = done_seen;
    ADDR = 9'h000; COUNT = 9'd511; READY = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    exp_a = 9'h000;
    xfers = 0;
    cyc = 0;
    ne_bad = 0;
    while (xfers < 512 && cyc < 20000) begin
      READY = 1'($urandom_range(0, 1));
      if (nE !== 1'b0) ne_bad++;
      if (VALID === 1'b1 && READY === 1'b1) begin
        check("sw_a", 16'(A), 16'(exp_a));
        check("sw_data", 16'(DATA), 16'(prom_val(exp_a)));
        xfers++;
        exp_a = exp_a + 9'd1;
      end
      tick();
      cyc++;
    end
    check("sw_xfers", 16'(xfers), 16'd512);
    check("sw_done", 16'(DONE), 16'd1);
    check("sw_ne_end", 16'(nE), 16'd1);
    check("sw_ne_gaps", 16'(ne_bad), 16'd0);
    wait_idle(10);
    check("sw_done_count", 16'(done_seen - base), 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
